// File: rtl/branch_target_predictor.sv
// Purpose : direct-mapped branch target buffer with 2-bit saturating direction
//           counters; predicts the next fetch PC and is trained by resolved
//           control-flow instructions from the memory stage.
// Latency : lookup is combinational (0 cycles); an update is visible to lookup
//           on the cycle after the clock edge that samples it (no bypass).
// Backpressure: none; one lookup and one update are accepted every cycle.
//
// Ports:
//   CLK, nRST           clock (rising edge), asynchronous active-low reset
//   fet_pc              fetch-stage PC to look up
//   pred_taken          lookup hit and counter MSB set
//   pred_npc            predicted next PC (stored target or fet_pc + 4)
//   upd_valid           resolved branch/jump present in MEM this cycle
//   upd_pc              PC of that instruction
//   upd_taken           actual outcome (1 = taken branch or jump)
//   upd_target          actual target address
//   upd_mispredict      fetch prediction was wrong (statistics only)
//   flush               invalidate every entry
//   stat_hits           number of clock edges at which the lookup hit
//   stat_mispredicts    number of clock edges with upd_valid & upd_mispredict
//
// Optional feature: define BTB_STATS_EN to implement the two 32-bit statistics
// counters. Without it both stat ports read 0 and upd_mispredict is ignored.

module branch_target_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] fet_pc,
    output logic        pred_taken,
    output logic [31:0] pred_npc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict,
    input  logic        flush,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_mispredicts
);

    localparam int TAG_W = 32 - IDX_W - 2;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [TAG_W-1:0] tag_t;

    // Entry storage, one slot per index.
    logic        valid_q  [ENTRIES];
    tag_t        tag_q    [ENTRIES];
    logic [31:0] target_q [ENTRIES];
    logic [1:0]  ctr_q    [ENTRIES];

    // ------------------------------------------------------------------
    // Lookup
    // ------------------------------------------------------------------
    idx_t fet_idx;
    tag_t fet_tag;
    logic fet_hit;

    assign fet_idx = fet_pc[IDX_W+1:2];
    assign fet_tag = fet_pc[31:IDX_W+2];

    // valid gates the tag compare, so stale tags left behind by a flush or
    // reset can never produce a hit.
    assign fet_hit    = valid_q[fet_idx] && (tag_q[fet_idx] == fet_tag);
    assign pred_taken = fet_hit && ctr_q[fet_idx][1];
    assign pred_npc   = pred_taken ? target_q[fet_idx] : (fet_pc + 32'd4);

    // ------------------------------------------------------------------
    // Update decode
    // ------------------------------------------------------------------
    idx_t        upd_idx;
    tag_t        upd_tag;
    logic        upd_hit;
    logic        wr_en;
    logic [1:0]  ctr_d;
    logic [31:0] target_d;

    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[31:IDX_W+2];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    always_comb begin
        wr_en    = 1'b0;
        ctr_d    = ctr_q[upd_idx];
        target_d = target_q[upd_idx];
        if (upd_valid) begin
            if (upd_hit) begin
                wr_en = 1'b1;
                if (upd_taken) begin
                    ctr_d    = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : (ctr_q[upd_idx] + 2'd1);
                    target_d = upd_target;
                end else begin
                    ctr_d    = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : (ctr_q[upd_idx] - 2'd1);
                end
            end else if (upd_taken) begin
                // Allocation: overwrites whatever entry currently owns the
                // index and starts weakly taken.
                wr_en    = 1'b1;
                ctr_d    = 2'b10;
                target_d = upd_target;
            end
            // Miss and not taken: nothing worth remembering.
        end
    end

    // ------------------------------------------------------------------
    // Entry state
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (flush) begin
            // Only valid is cleared; counters and targets are retained.
            // A simultaneous update is dropped.
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (wr_en) begin
            valid_q[upd_idx]  <= 1'b1;
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= target_d;
            ctr_q[upd_idx]    <= ctr_d;
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef BTB_STATS_EN
    logic [31:0] stat_hits_q, stat_hits_d;
    logic [31:0] stat_mis_q,  stat_mis_d;

    // Counting is independent of stall and flush; both counters wrap.
    always_comb begin
        stat_hits_d = stat_hits_q + {31'd0, fet_hit};
        stat_mis_d  = stat_mis_q  + {31'd0, (upd_valid & upd_mispredict)};
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_hits_q <= '0;
            stat_mis_q  <= '0;
        end else begin
            stat_hits_q <= stat_hits_d;
            stat_mis_q  <= stat_mis_d;
        end
    end

    assign stat_hits        = stat_hits_q;
    assign stat_mispredicts = stat_mis_q;

    logic unused_bits;
    assign unused_bits = ^{fet_pc[1:0], upd_pc[1:0]};
`else
    assign stat_hits        = '0;
    assign stat_mispredicts = '0;

    logic unused_bits;
    assign unused_bits = ^{fet_pc[1:0], upd_pc[1:0], upd_mispredict};
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
module tb_branch_target_predictor;

    localparam int ENTRIES = 16;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] fet_pc;
    logic        pred_taken;
    logic [31:0] pred_npc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic        flush;
    logic [31:0] stat_hits;
    logic [31:0] stat_mispredicts;

    branch_target_predictor #(.ENTRIES(ENTRIES)) dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .fet_pc           (fet_pc),
        .pred_taken       (pred_taken),
        .pred_npc         (pred_npc),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_mispredict   (upd_mispredict),
        .flush            (flush),
        .stat_hits        (stat_hits),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: each slot remembers the word address of the
    // instruction that owns it, so a hit is simply "same word address".
    // ------------------------------------------------------------------
    bit          m_v    [ENTRIES];
    logic [29:0] m_word [ENTRIES];
    logic [31:0] m_tgt  [ENTRIES];
    int          m_ctr  [ENTRIES];
    logic [31:0] m_hits;
    logic [31:0] m_mis;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_v[slot(pc)] && (m_word[slot(pc)] == pc[31:2]);
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_v[i] = 0; m_word[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
            end
            m_hits = '0;
            m_mis  = '0;
        end else begin
            int s;
            if (m_hit(fet_pc)) m_hits = m_hits + 32'd1;
            if (upd_valid && upd_mispredict) m_mis = m_mis + 32'd1;
            s = slot(upd_pc);
            if (flush) begin
                for (int i = 0; i < ENTRIES; i++) m_v[i] = 0;
            end else if (upd_valid) begin
                if (m_hit(upd_pc)) begin
                    if (upd_taken) begin
                        m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
                        m_tgt[s] = upd_target;
                    end else begin
                        m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
                    end
                end else if (upd_taken) begin
                    m_v[s] = 1; m_word[s] = upd_pc[31:2]; m_tgt[s] = upd_target; m_ctr[s] = 2;
                end
            end
        end
    end

    // Compare process: every cycle, outputs against the model.
    bit run_cmp = 0;
    always @(negedge CLK) begin
        if (run_cmp) begin
            bit          et;
            logic [31:0] en;
            et = m_hit(fet_pc) && (m_ctr[slot(fet_pc)] >= 2);
            en = et ? m_tgt[slot(fet_pc)] : fet_pc + 32'd4;
            chk("cmp_pred_taken", {31'd0, pred_taken}, {31'd0, et});
            chk("cmp_pred_npc", pred_npc, en);
`ifdef BTB_STATS_EN
            chk("cmp_stat_hits", stat_hits, m_hits);
            chk("cmp_stat_mis", stat_mispredicts, m_mis);
`else
            chk("cmp_stat_hits_zero", stat_hits, 32'd0);
            chk("cmp_stat_mis_zero", stat_mispredicts, 32'd0);
`endif
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers (called 1 time unit after a rising edge)
    // ------------------------------------------------------------------
    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic misp, input logic fl);
        upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
        upd_mispredict = misp; flush = fl;
        @(posedge CLK); #1;
        upd_valid = 1'b0; upd_mispredict = 1'b0; flush = 1'b0;
    endtask

    task automatic look(input string name, input logic [31:0] pc,
                        input logic exp_tk, input logic [31:0] exp_npc);
        fet_pc = pc;
        #1;
        chk({name, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_tk});
        chk({name, "_npc"}, pred_npc, exp_npc);
    endtask

    task automatic next_cycle();
        @(posedge CLK); #1;
    endtask

    function automatic logic [31:0] rand_pc();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0040;
            1: return 32'h0000_0080;
            2: return 32'h0000_0010;
            3: return 32'h0000_1044;
            4: return {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        nRST = 1'b0; fet_pc = 32'h40; upd_valid = 0; upd_pc = 0; upd_taken = 0;
        upd_target = 0; upd_mispredict = 0; flush = 0;
        #2;
        look("reset", 32'h40, 1'b0, 32'h44);
        chk("reset_stat_hits", stat_hits, 32'd0);
        chk("reset_stat_mis", stat_mispredicts, 32'd0);
        next_cycle();
        next_cycle();
        nRST = 1'b1;
        run_cmp = 1;
        next_cycle();

        // Same-cycle lookup/update: pre-update contents are returned.
        fet_pc = 32'h40;
        upd_valid = 1; upd_pc = 32'h40; upd_taken = 1; upd_target = 32'h100;
        #1;
        chk("same_cycle_taken", {31'd0, pred_taken}, 32'd0);
        @(posedge CLK); #1;
        upd_valid = 0;
        look("alloc", 32'h40, 1'b1, 32'h100);

        // Counter walk down and saturation at 00.
        upd(32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
        look("ctr01", 32'h40, 1'b0, 32'h44);
        upd(32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
        look("ctr00", 32'h40, 1'b0, 32'h44);
        upd(32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
        upd(32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
        look("ctr_held_00", 32'h40, 1'b0, 32'h44);
        upd(32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
        look("ctr_back_10", 32'h40, 1'b1, 32'h100);

        // Alias on the same index, different tag.
        look("alias_miss", 32'h80, 1'b0, 32'h84);
        upd(32'h80, 1'b1, 32'h200, 1'b0, 1'b0);
        look("alias_new", 32'h80, 1'b1, 32'h200);
        look("alias_evicted", 32'h40, 1'b0, 32'h44);

        // Flush wins over a simultaneous update.
        upd(32'h10, 1'b1, 32'h300, 1'b0, 1'b1);
        look("flush_drop", 32'h10, 1'b0, 32'h14);
        look("flush_inval", 32'h80, 1'b0, 32'h84);
        upd(32'h10, 1'b1, 32'h300, 1'b0, 1'b0);
        look("realloc", 32'h10, 1'b1, 32'h300);
        upd(32'h10, 1'b0, 32'h0, 1'b0, 1'b0);
        look("realloc_ctr10", 32'h10, 1'b0, 32'h14);

        // Reset asserted while an update is pending: update is lost.
        upd_valid = 1; upd_pc = 32'h80; upd_taken = 1; upd_target = 32'h500;
        #1 nRST = 1'b0;
        look("rst_mid_upd", 32'h80, 1'b0, 32'h84);
        @(posedge CLK); #1;
        upd_valid = 0;
        nRST = 1'b1;
        look("rst_after", 32'h10, 1'b0, 32'h14);

`ifdef BTB_STATS_EN
        fet_pc = 32'h1000;
        next_cycle();
        upd(32'h40, 1'b1, 32'h100, 1'b1, 1'b0);
        fet_pc = 32'h40;
        upd_valid = 1; upd_pc = 32'h2000; upd_taken = 0; upd_mispredict = 1;
        next_cycle();
        upd_valid = 0; upd_mispredict = 0;
        next_cycle();
        next_cycle();
        fet_pc = 32'h1000;
        #1;
        chk("stat_hits_3", stat_hits, 32'd3);
        chk("stat_mis_2", stat_mispredicts, 32'd2);
        fet_pc = 32'h40;
        force dut.stat_hits_q = 32'hFFFF_FFFF;
        m_hits = 32'hFFFF_FFFF;
        #1 release dut.stat_hits_q;
        next_cycle();
        chk("stat_hits_wrap", stat_hits, 32'd0);
`endif

        // Randomised traffic against the model.
        repeat (3000) begin
            fet_pc         = rand_pc();
            upd_valid      = ($urandom_range(0, 2) != 0);
            upd_pc         = rand_pc();
            upd_taken      = $urandom_range(0, 1);
            upd_target     = $urandom & 32'hFFFF_FFFC;
            upd_mispredict = $urandom_range(0, 1);
            flush          = ($urandom_range(0, 40) == 0);
            next_cycle();
        end
        upd_valid = 0; flush = 0;
        next_cycle();
        run_cmp = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
